// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

    localparam int SEL_W  = 3;
    localparam int NUM_CH = 8;
    localparam int CNT_W  = 4;

    // Scan sequencer states. The S_ prefix keeps the literals distinct from
    // the SETTLE parameter of the top module.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational next-channel finder: the lowest set mask bit strictly above
// cur, or the lowest set bit overall when first is high.
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              first,
    output logic [SEL_W-1:0]  nxt,
    output logic              found
);

    // Descending search so the last hit, the lowest qualifying bit, wins.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_seq.sv
// Scan sequencer: steps the 8-to-1 mux select through the enabled channels,
// waits SETTLE cycles on each, samples mux_out and hands the assembled word
// downstream.
// Handshake: word/word_valid are held stable from the rise of word_valid
// until the edge where word_valid & word_ready are both high; that edge is
// the transfer, and word_ready is ignored while word_valid is low.
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_cont,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [NUM_CH-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output state_t            state_dbg
);

    // Entry state for each channel: skip SETTLE entirely when no wait is set.
    localparam state_t          ENTRY_ST   = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SEL_W-1:0]   sel_n;
    logic [NUM_CH-1:0]  snap, snap_n;
    logic [NUM_CH-1:0]  shadow, shadow_n;
    logic [NUM_CH-1:0]  word_n;
    logic               valid_n;

    logic [SEL_W-1:0]   first_nxt, adv_nxt;
    logic               first_found, adv_found;

    // Scan start: lowest enabled channel of the live mask.
    mux_scan_next_ch u_first (
        .mask  (ch_mask),
        .cur   ('0),
        .first (1'b1),
        .nxt   (first_nxt),
        .found (first_found)
    );

    // Advance: next enabled channel above the current one in the snapshot.
    mux_scan_next_ch u_adv (
        .mask  (snap),
        .cur   (sel),
        .first (1'b0),
        .nxt   (adv_nxt),
        .found (adv_found)
    );

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // State and datapath registers; reset aborts any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sel        <= '0;
            snap       <= '0;
            shadow     <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
            snap       <= snap_n;
            shadow     <= shadow_n;
            word       <= word_n;
            word_valid <= valid_n;
        end
    end

    // Next-state and datapath decisions.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sel_n    = sel;
        snap_n   = snap;
        shadow_n = shadow;
        word_n   = word;
        valid_n  = word_valid;
        case (state)
            S_IDLE: begin
                if (start && first_found) begin
                    snap_n   = ch_mask;
                    shadow_n = '0;
                    sel_n    = first_nxt;
                    cnt_n    = SETTLE_CNT;
                    state_n  = ENTRY_ST;
                end
            end
            S_SETTLE: begin
                if (cnt <= CNT_W'(1)) begin
                    state_n = S_SAMPLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_SAMPLE: begin
                shadow_n[sel] = mux_out;
                if (adv_found) begin
                    sel_n   = adv_nxt;
                    cnt_n   = SETTLE_CNT;
                    state_n = ENTRY_ST;
                end else begin
                    word_n  = shadow_n;
                    valid_n = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (word_ready) begin
                    valid_n = 1'b0;
                    if (mode_cont && first_found) begin
                        snap_n   = ch_mask;
                        shadow_n = '0;
                        sel_n    = first_nxt;
                        cnt_n    = SETTLE_CNT;
                        state_n  = ENTRY_ST;
                    end else begin
                        sel_n   = '0;
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq with three settle settings side by side.
module tb_mux_scan_seq;
    import mux_scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode_cont;
    logic [7:0] ch_mask;
    logic       word_ready;
    logic [7:0] mux_in;

    logic [2:0] sel_1, sel_0, sel_2;
    logic       busy_1, busy_0, busy_2;
    logic [7:0] word_1, word_0, word_2;
    logic       valid_1, valid_0, valid_2;
    state_t     st_1, st_0, st_2;
    logic       mux_out_1, mux_out_0, mux_out_2;

    int checks = 0;
    int errors = 0;

    // Bench-side model of the 8-to-1 mux for each instance.
    assign mux_out_1 = mux_in[sel_1];
    assign mux_out_0 = mux_in[sel_0];
    assign mux_out_2 = mux_in[sel_2];

    always #5 clk = ~clk;

    mux_scan_seq #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start), .mode_cont(mode_cont),
        .ch_mask(ch_mask), .mux_out(mux_out_1), .sel(sel_1), .busy(busy_1),
        .word(word_1), .word_valid(valid_1), .word_ready(word_ready),
        .state_dbg(st_1)
    );

    mux_scan_seq #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start), .mode_cont(mode_cont),
        .ch_mask(ch_mask), .mux_out(mux_out_0), .sel(sel_0), .busy(busy_0),
        .word(word_0), .word_valid(valid_0), .word_ready(word_ready),
        .state_dbg(st_0)
    );

    mux_scan_seq #(.SETTLE(2)) u_s2 (
        .clk(clk), .rst(rst), .start(start), .mode_cont(mode_cont),
        .ch_mask(ch_mask), .mux_out(mux_out_2), .sel(sel_2), .busy(busy_2),
        .word(word_2), .word_valid(valid_2), .word_ready(word_ready),
        .state_dbg(st_2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        mode_cont  = 1'b0;
        ch_mask    = 8'h00;
        word_ready = 1'b0;
        mux_in     = 8'h00;
        repeat (2) tick();
        check("rst_sel",   sel_1,   8'h00);
        check("rst_busy",  busy_1,  8'h00);
        check("rst_word",  word_1,  8'h00);
        check("rst_valid", valid_1, 8'h00);
        check("rst_state", st_1,    S_IDLE);
        rst = 1'b0;

        // Full scan, SETTLE=1: two cycles per channel, word at edge 16.
        ch_mask = 8'hFF;
        mux_in  = 8'b1010_0110;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 16; e++) begin
            check($sformatf("walk_sel_e%0d", e), sel_1, 8'(e / 2));
            check($sformatf("walk_valid_e%0d", e), valid_1, 8'h00);
            tick();
        end
        check("walk_valid16", valid_1, 8'h01);
        check("walk_word16",  word_1,  8'hA6);

        // Held word under backpressure with toggling mux inputs.
        for (int i = 0; i < 5; i++) begin
            mux_in = 8'($urandom_range(0, 255));
            tick();
            check($sformatf("hold_valid_%0d", i), valid_1, 8'h01);
            check($sformatf("hold_word_%0d", i),  word_1,  8'hA6);
        end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("accept_valid", valid_1, 8'h00);
        check("accept_busy",  busy_1,  8'h00);
        check("accept_sel",   sel_1,   8'h00);
        check("accept_state", st_1,    S_IDLE);

        // SETTLE=0, sparse mask: visits 0,2,7 only, word at edge 3.
        do_reset();
        ch_mask    = 8'b1000_0101;
        mux_in     = 8'hFF;
        word_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("sparse_sel0", sel_0, 8'h00);
        tick();
        check("sparse_sel1", sel_0, 8'h02);
        tick();
        check("sparse_sel2",   sel_0,   8'h07);
        check("sparse_valid2", valid_0, 8'h00);
        tick();
        check("sparse_valid3", valid_0, 8'h01);
        check("sparse_word3",  word_0,  8'h85);
        tick();
        check("sparse_valid4", valid_0, 8'h00);
        check("sparse_busy4",  busy_0,  8'h00);

        // Continuous mode, SETTLE=2, two channels: word 6 edges after each scan start.
        do_reset();
        word_ready = 1'b1;
        mode_cont  = 1'b1;
        ch_mask    = 8'h03;
        mux_in     = 8'h02;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            check($sformatf("cont_valid_e%0d", e), valid_2, 8'((e == 6) || (e == 13)));
            if (e == 6) check("cont_word6", word_2, 8'h02);
        end
        tick();
        check("cont_rescan_busy",  busy_2,  8'h01);
        check("cont_rescan_valid", valid_2, 8'h00);
        mode_cont = 1'b0;
        for (int e = 15; e <= 20; e++) begin
            tick();
            check($sformatf("cont_last_e%0d", e), valid_2, 8'(e == 20));
        end
        tick();
        check("cont_end_busy",  busy_2,  8'h00);
        check("cont_end_sel",   sel_2,   8'h00);
        check("cont_end_valid", valid_2, 8'h00);

        // Empty mask start is ignored; start while busy and mask changes are ignored.
        do_reset();
        word_ready = 1'b1;
        ch_mask    = 8'h00;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("empty_busy",  busy_1,  8'h00);
        check("empty_state", st_1,    S_IDLE);
        check("empty_valid", valid_1, 8'h00);
        tick();
        check("empty_busy2", busy_1, 8'h00);
        ch_mask = 8'h10;
        mux_in  = 8'h10;
        start   = 1'b1;
        tick();
        check("busy_start_busy", busy_1, 8'h01);
        check("busy_start_sel",  sel_1,  8'h04);
        ch_mask = 8'h01;
        tick();
        start = 1'b0;
        check("busy_start_valid1", valid_1, 8'h00);
        check("busy_start_sel1",   sel_1,   8'h04);
        tick();
        check("busy_start_valid2", valid_1, 8'h01);
        check("busy_start_word2",  word_1,  8'h10);
        tick();
        check("busy_start_idle", busy_1, 8'h00);

        // Asynchronous reset during settle of channel 3 aborts the scan.
        word_ready = 1'b0;
        ch_mask    = 8'hFF;
        mux_in     = 8'h00;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("abort_pre_sel",   sel_1, 8'h03);
        check("abort_pre_state", st_1,  S_SETTLE);
        #2 rst = 1'b1;
        #1;
        check("abort_sel",   sel_1,   8'h00);
        check("abort_busy",  busy_1,  8'h00);
        check("abort_valid", valid_1, 8'h00);
        check("abort_word",  word_1,  8'h00);
        tick();
        rst    = 1'b0;
        mux_in = 8'h5A;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check("rescan_valid15", valid_1, 8'h00);
        tick();
        check("rescan_valid16", valid_1, 8'h01);
        check("rescan_word16",  word_1,  8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
